three_eight_decoder_seq: RTL and testbench
==========================================

THREE_EIGHT_DECODER_SEQ -- requirements
Module: three_eight_decoder_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose parameter HOLD_CYCLES, default 4, giving the number of cycles each decoded one-hot output is held (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning a code is offered.
REQ-006 The block SHALL have port in_code, input, 3 bits, the binary code to decode.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a code this cycle.
REQ-008 The block SHALL have port out, output, 8 bits, the registered one-hot decode.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out carries a decoded value.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse at the end of each hold.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and HOLD.
REQ-012 in_ready SHALL be 1 only in IDLE; a handshake occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-013 On a handshake, the next state SHALL be HOLD, out SHALL be 1 shifted left by in_code, out_valid SHALL be 1, and the hold counter SHALL load HOLD_CYCLES-1.
REQ-014 Latency: out SHALL be valid in the cycle after the handshake edge and held unchanged for exactly HOLD_CYCLES cycles.
REQ-015 In HOLD with a nonzero counter, the counter SHALL decrement by 1 per cycle; in_code and in_valid SHALL be ignored.
REQ-016 In HOLD with counter 0, the next edge SHALL return to IDLE, clear out to 8'h00 and out_valid to 0, and assert done for that one IDLE cycle.
REQ-017 Back-to-back codes SHALL therefore be separated by at least one cycle with out = 8'h00 (the idle/done cycle).
REQ-018 out SHALL always be 8'h00 or contain exactly one set bit; out_valid SHALL be 1 iff out is nonzero.
REQ-019 The counter width SHALL be 8 bits; HOLD_CYCLES = 1 SHALL load 0 and hold for exactly one cycle.

Reset
REQ-020 When rst is 1 at an edge, the block SHALL enter IDLE with out = 8'h00, out_valid = 0, done = 0, counter = 0, and in_ready = 1 from the following cycle.
REQ-021 Reset asserted mid-HOLD SHALL abort the hold with no done pulse; reset SHALL take priority over a simultaneous handshake.
REQ-022 in_ready SHALL be 0 while rst is 1.

Configuration
REQ-023 Macro THREE_EIGHT_DECODER_SCAN_EN, when defined, SHALL add input port scan_en (1 bit) and an internal 3-bit scan counter that resets to 0.
REQ-024 With the macro defined, in IDLE with in_valid = 0 and scan_en = 1, the block SHALL self-accept the scan counter value as the code and then increment the counter modulo 8 (7 wraps to 0).
REQ-025 With the macro defined, in_valid = 1 SHALL take priority over scan, and the scan counter SHALL not advance on an external handshake.
REQ-026 Without the macro, there SHALL be no scan_en port and no scan counter, and behaviour SHALL match REQ-011..REQ-022 only.

Structure
REQ-027 Package three_eight_decoder_pkg SHALL hold the state enumeration (IDLE, HOLD), CODE_W = 3, and OUT_W = 8.
REQ-028 The hold counter (load, decrement, zero flag) SHALL be one sub-module named hold_timer; decode and the FSM SHALL stay in the top module.

Verification
REQ-029 Reset with HOLD_CYCLES = 4: assert rst for 2 cycles -> out = 00, out_valid = 0, done = 0, and in_ready = 1 after release.
REQ-030 Sweep codes 0..7 with in_valid held high -> out = 01, 02, 04, ... 80, each for 4 cycles, each followed by one cycle of out = 00 with done = 1.
REQ-031 Offer code 5 during HOLD of code 2 -> out stays 04 and in_ready = 0; code 5 is accepted on the idle cycle and out = 20 next.
REQ-032 Assert rst on the 2nd HOLD cycle of code 3 -> out = 00 next cycle and no done pulse.
REQ-033 HOLD_CYCLES = 1, code 7 -> out = 80 for exactly one cycle, then out = 00 with done = 1.
REQ-034 SCAN_EN defined, scan_en = 1, in_valid = 0 for 50 cycles -> out = 01, 02, ... 80, then 01 (wrap); inject in_valid with code 0 mid-scan -> the external code wins and the scan sequence resumes without skipping.

Source files
------------

// File: rtl/three_eight_decoder_pkg.sv
// Shared types and widths for the sequential 3-to-8 decoder.
// Holds the FSM state enumeration and the one-hot decode helper.
package three_eight_decoder_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [OUT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter that times how long a decoded value is held.
// Loads HOLD_CYCLES-1, decrements to zero and flags zero.
module hold_timer
  import three_eight_decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_zero;

  assign w_zero = (r_count == '0);

  // Load wins over decrement; the count never wraps below zero.
  always_comb begin
    w_count_next = r_count;
    if (i_load) begin
      w_count_next = LoadVal;
    end else if (i_dec && !w_zero) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_zero = w_zero;

endmodule

// File: rtl/three_eight_decoder_seq.sv
// Sequential 3-to-8 decoder: accepts a code in IDLE, holds its one-hot decode for
// HOLD_CYCLES cycles, then pulses done. Optional THREE_EIGHT_DECODER_SCAN_EN adds scan_en.
module three_eight_decoder_seq
  import three_eight_decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef THREE_EIGHT_DECODER_SCAN_EN
  input  logic              scan_en,
`endif
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic              done
);

  state_e            r_state;
  state_e            w_state_next;
  logic [OUT_W-1:0]  r_out;
  logic              r_out_valid;
  logic              r_done;
  logic              w_accept;
  logic [CODE_W-1:0] w_code;
  logic              w_load;
  logic              w_dec;
  logic              w_zero;
  logic              w_hold_end;

`ifdef THREE_EIGHT_DECODER_SCAN_EN
  logic [CODE_W-1:0] r_scan;
  logic              w_accept_scan;

  // External codes take priority; the scan counter only advances on a self-accept.
  assign w_accept_scan = in_ready && !in_valid && scan_en;
  assign w_accept      = (in_ready && in_valid) || w_accept_scan;
  assign w_code        = in_valid ? in_code : r_scan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
    end else if (w_accept_scan) begin
      r_scan <= r_scan + CODE_W'(1);
    end
  end
`else
  assign w_accept = in_ready && in_valid;
  assign w_code   = in_code;
`endif

  assign w_hold_end = (r_state == HOLD) && w_zero;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_dec (w_dec),
    .o_zero(w_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_next = HOLD;
      HOLD: if (w_zero)   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs; in_ready is gated by rst so nothing is accepted during reset.
  always_comb begin
    in_ready = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = !rst;
        w_load   = w_accept;
      end
      HOLD: w_dec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_hold_end;
      if (w_accept) begin
        r_out       <= decode_onehot(w_code);
        r_out_valid <= 1'b1;
      end else if (w_hold_end) begin
        r_out       <= '0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_three_eight_decoder_seq.sv
// Bench for three_eight_decoder_seq: two instances (HOLD_CYCLES 4 and 1) share stimulus and are
// checked every cycle against a timestamp-based model. Honours THREE_EIGHT_DECODER_SCAN_EN.
module tb_three_eight_decoder_seq;

`ifdef THREE_EIGHT_DECODER_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       in_valid = 1'b0;
  logic       scan_en  = 1'b0;
  logic [2:0] in_code  = 3'd0;

  logic       rdy0, rdy1, ov0, ov1, dn0, dn1;
  logic [7:0] out0, out1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] oh_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  always #5 clk = ~clk;

  three_eight_decoder_seq #(.HOLD_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef THREE_EIGHT_DECODER_SCAN_EN
    .scan_en  (scan_en),
`endif
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (rdy0),
    .out      (out0),
    .out_valid(ov0),
    .done     (dn0)
  );

  three_eight_decoder_seq #(.HOLD_CYCLES(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
`ifdef THREE_EIGHT_DECODER_SCAN_EN
    .scan_en  (scan_en),
`endif
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (rdy1),
    .out      (out1),
    .out_valid(ov1),
    .done     (dn1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance remembers the edge index at which it last accepted a code.
  int         edge_n = 0;
  int         hc     [2] = '{4, 1};
  bit         m_busy [2] = '{1'b0, 1'b0};
  int         m_acc  [2] = '{0, 0};
  logic [2:0] m_code [2] = '{3'd0, 3'd0};
  logic [2:0] m_scan [2] = '{3'd0, 3'd0};

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit rdy;
      rdy = !rst && !(m_busy[i] && (edge_n - m_acc[i]) < hc[i]);
      if (rst) begin
        m_busy[i] = 1'b0;
        m_scan[i] = 3'd0;
      end else if (rdy && in_valid) begin
        m_busy[i] = 1'b1;
        m_acc[i]  = edge_n + 1;
        m_code[i] = in_code;
      end else if (rdy && SCAN && scan_en) begin
        m_busy[i] = 1'b1;
        m_acc[i]  = edge_n + 1;
        m_code[i] = m_scan[i];
        m_scan[i] = m_scan[i] + 3'd1;
      end
    end
    edge_n++;
  end

  initial forever begin
    @(negedge clk);
    if (edge_n > 0) begin
      for (int i = 0; i < 2; i++) begin
        bit         act;
        logic [7:0] e_out;
        logic       e_done, e_rdy;
        logic [7:0] a_out;
        logic       a_ov, a_dn, a_rdy;
        act    = m_busy[i] && (edge_n - m_acc[i]) < hc[i];
        e_out  = act ? 8'(1 << m_code[i]) : 8'h00;
        e_done = m_busy[i] && (edge_n - m_acc[i]) == hc[i];
        e_rdy  = !rst && !act;
        a_out  = (i == 0) ? out0 : out1;
        a_ov   = (i == 0) ? ov0  : ov1;
        a_dn   = (i == 0) ? dn0  : dn1;
        a_rdy  = (i == 0) ? rdy0 : rdy1;
        chk($sformatf("model_out[%0d]", i),   a_out, e_out);
        chk($sformatf("model_valid[%0d]", i), {7'd0, a_ov}, {7'd0, e_out != 8'h00});
        chk($sformatf("model_done[%0d]", i),  {7'd0, a_dn}, {7'd0, e_done});
        chk($sformatf("model_ready[%0d]", i), {7'd0, a_rdy}, {7'd0, e_rdy});
        chk($sformatf("onehot[%0d]", i), 8'($countones(a_out) <= 1), 8'h01);
      end
    end
  end

  initial begin
    // Reset held for two edges.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out", out0, 8'h00);
    chk("rst_valid", {7'd0, ov0}, 8'h00);
    chk("rst_done", {7'd0, dn0}, 8'h00);
    chk("rst_ready_low", {7'd0, rdy0}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {7'd0, rdy0}, 8'h01);
    chk("post_rst_out", out0, 8'h00);

    // Sweep 0..7 with in_valid held high.
    in_code  = 3'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("sweep_first[%0d]", c), out0, oh_tbl[c]);
      repeat (3) @(negedge clk);
      chk($sformatf("sweep_last[%0d]", c), out0, oh_tbl[c]);
      in_code = 3'(c + 1);
      @(negedge clk);
      chk($sformatf("sweep_gap_out[%0d]", c), out0, 8'h00);
      chk($sformatf("sweep_gap_done[%0d]", c), {7'd0, dn0}, 8'h01);
      if (c == 7) in_valid = 1'b0;
    end
    repeat (3) @(negedge clk);

    // HOLD_CYCLES = 1 with code 7.
    in_code  = 3'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("h1_out", out1, 8'h80);
    chk("h4_out_same_edge", out0, 8'h80);
    @(negedge clk);
    chk("h1_out_cleared", out1, 8'h00);
    chk("h1_done", {7'd0, dn1}, 8'h01);
    chk("h4_still_held", out0, 8'h80);
    repeat (5) @(negedge clk);

    // Code offered during a hold is ignored until the idle cycle.
    in_code  = 3'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_code = 3'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("busy_out[%0d]", k), out0, 8'h04);
      chk($sformatf("busy_ready[%0d]", k), {7'd0, rdy0}, 8'h00);
    end
    @(negedge clk);
    chk("busy_gap_out", out0, 8'h00);
    chk("busy_gap_done", {7'd0, dn0}, 8'h01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_next_out", out0, 8'h20);
    repeat (6) @(negedge clk);

    // Reset on the second hold cycle aborts without done.
    in_code  = 3'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_in_rst", {7'd0, rdy0}, 8'h00);
    chk("abort_out_before", out0, 8'h08);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out", out0, 8'h00);
    chk("abort_valid", {7'd0, ov0}, 8'h00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort_no_done[%0d]", k), {7'd0, dn0}, 8'h00);
    end

    // Scan phase (an idle run when the scan option is not built in).
    scan_en = 1'b1;
    @(posedge clk); #1;
`ifdef THREE_EIGHT_DECODER_SCAN_EN
    @(negedge clk);
    chk("scan_first", out0, 8'h01);
`endif
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (k == 22) begin
        in_code  = 3'd0;
        in_valid = 1'b1;
      end
      if (k == 27) in_valid = 1'b0;
    end
    scan_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Randomised traffic, including reset colliding with handshakes.
    for (int k = 0; k < 1500; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_code  = 3'($urandom_range(0, 7));
      scan_en  = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    scan_en  = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
